// File: rtl/embedded_system_onchip_memory_pipelined.sv
// Single-port on-chip RAM behind an Avalon-MM slave with a configurable read pipeline,
// clock-enable stall and SLVERR for addresses beyond the implemented depth.
module embedded_system_onchip_memory_pipelined #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 15,
    parameter int DEPTH        = 25000,
    parameter int READ_LATENCY = 2,
    parameter     INIT_FILE    = "embedded_system_onchip_memory2_0.hex"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    input  logic                      chipselect,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic                      clken,
    input  logic                      reset_req,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      readdatavalid,
    output logic [1:0]                response,
    output logic                      waitrequest
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
            $error("READ_LATENCY must be 1..3");
        end
        if (DATA_WIDTH % 8 != 0) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of 8");
        end
        if (DEPTH < 1 || DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
            $error("DEPTH must be 1..2**ADDR_WIDTH");
        end
    endgenerate

    logic run;
    logic in_range;
    logic wr_acc;
    logic rd_acc;

    assign run         = clken & ~reset_req;
    assign waitrequest = ~run;
    assign in_range    = ({1'b0, address} < DEPTH_EXT);
    // A combined read+write is a write only; the read half never enters the pipeline.
    assign wr_acc      = chipselect & write & run & ~reset;
    assign rd_acc      = chipselect & read & ~write & run & ~reset;

    // Contents are preloaded by the device toolchain from the named image, if any.
    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (byteenable[b]) begin
                    mem[address][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    logic [READ_LATENCY-1:0] vld_p;
    logic [READ_LATENCY-1:0] err_p;
    logic [DATA_WIDTH-1:0]   data_p [READ_LATENCY];

    // Stage 0 is the registered RAM read; later stages only delay it.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
        end else if (run) begin
            vld_p[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (run) begin
            data_p[0] <= mem[address];
            err_p[0]  <= ~in_range;
            for (int i = 1; i < READ_LATENCY; i++) begin
                data_p[i] <= data_p[i-1];
                err_p[i]  <= err_p[i-1];
            end
        end
    end

    // Output stage: held entries are masked while stalled and released when run returns.
    assign readdatavalid = vld_p[READ_LATENCY-1] & run & ~reset;
    assign readdata      = (readdatavalid && !err_p[READ_LATENCY-1]) ? data_p[READ_LATENCY-1]
                                                                     : '0;
    assign response      = (readdatavalid && err_p[READ_LATENCY-1]) ? RESP_SLVERR : RESP_OKAY;

endmodule
